burst_rom: RTL and testbench

// - Parametrised synchronous program ROM for the 5-stage core; supersedes the combinational tri-state ROM.
// - Accepts a start address + burst length over a valid/ready handshake and returns sequential beats

---
 rtl/burst_rom_pkg.sv | 25 ++
 rtl/burst_rom_rd_pipe.sv | 67 ++++++
 rtl/burst_rom.sv | 126 ++++++++++++
 tb/tb_burst_rom.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_rom_pkg.sv
// rtl/burst_rom_pkg.sv - shared types and parameter helpers for burst_rom
//
// Purpose: FSM state encoding, legal read-latency bounds and width helpers
// used by burst_rom and its read pipeline.
// Ports: none (package).
package burst_rom_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  // Width of the req_len field (beats-1) for a given maximum burst size.
  function automatic int len_width(input int max_burst);
    return $clog2(max_burst);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/burst_rom_rd_pipe.sv
// rtl/burst_rom_rd_pipe.sv - read response delay line for burst_rom
//
// Purpose: delays {valid, last, data} of each issued beat so the response
// leaves DEPTH cycles after issue. Synchronous flush on reset.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset (flushes stages)
//   in_valid, in_last    beat issued this cycle (enter stage 0 at the edge)
//   in_data              registered RAM output, aligned with stage 0
//   out_valid, out_last  delayed beat qualifiers
//   out_data             delayed beat data (holds when no beat moves)
module rom_rd_pipe #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] lst;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      lst <= '0;
    end else begin
      vld[0] <= in_valid;
      lst[0] <= in_last;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        lst[i] <= lst[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_last  = lst[DEPTH-1];

  // The RAM's own output register already is the data for stage 0, so data
  // stages start at index 1. Stages only load when a beat moves into them,
  // which keeps the output data stable between beats.
  if (DEPTH == 1) begin : g_direct
    assign out_data = in_data;
  end else begin : g_stages
    logic [DATA_WIDTH-1:0] dat [1:DEPTH-1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 1; i < DEPTH; i++) dat[i] <= '0;
      end else begin
        if (vld[0]) dat[1] <= in_data;
        for (int i = 2; i < DEPTH; i++) begin
          if (vld[i-1]) dat[i] <= dat[i-1];
        end
      end
    end

    assign out_data = dat[DEPTH-1];
  end

endmodule

// File: rtl/burst_rom.sv
// rtl/burst_rom.sv - synchronous burst-read program ROM with preload port
//
// Purpose: accepts {addr, len} bursts over a valid/ready handshake and returns
// len+1 sequential beats RD_LATENCY cycles after each beat is issued. Memory
// can be written through the load port while no burst is running.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         burst request handshake
//   req_addr, req_len           first beat address, beats-1
//   rsp_valid/rsp_data/rsp_last response beats, last flags final beat
//   ld_en/ld_addr/ld_data       memory preload write
//   ld_err                      one-cycle pulse when a load hits a burst
module burst_rom
  import burst_rom_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 16,
  parameter int LOAD_EN    = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [len_width(MAX_BURST)-1:0] req_len,
  output logic                            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            rsp_last,
  input  logic                            ld_en,
  input  logic [ADDR_WIDTH-1:0]           ld_addr,
  input  logic [DATA_WIDTH-1:0]           ld_data,
  output logic                            ld_err
);

  localparam int LEN_W = len_width(MAX_BURST);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
    $error("burst_rom: RD_LATENCY must be within 1..3");
  end
  if (!is_pow2(MAX_BURST) || MAX_BURST < 2) begin : g_bad_burst
    $error("burst_rom: MAX_BURST must be a power of 2 and >= 2");
  end

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_W-1:0]      count_q;
  logic                  ld_act;
  logic                  ld_wr;
  logic                  accept;
  logic                  issue;
  logic                  issue_last;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [DATA_WIDTH-1:0] rd_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign ld_act = (LOAD_EN != 0) && ld_en;
  assign ld_wr  = ld_act && rst_n && (state == IDLE);

  // A load in IDLE wins over a same-cycle request, so ready drops with ld_en.
  assign req_ready = rst_n && (state == IDLE) && !ld_act;
  assign accept    = req_valid && req_ready;

  // Beat 0 is issued straight from the request in the accept cycle; later
  // beats come from the address/count registers.
  assign issue      = accept || (state == BURST);
  assign issue_addr = (state == IDLE) ? req_addr : addr_q;
  assign issue_last = (state == IDLE) ? (req_len == '0) : (count_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      ld_err  <= 1'b0;
    end else begin
      ld_err <= ld_act && (state == BURST);
      case (state)
        IDLE: begin
          if (accept) begin
            // count_q tracks beats remaining after the one issued next
            addr_q  <= req_addr + ADDR_WIDTH'(1);
            count_q <= req_len - LEN_W'(1);
            if (req_len != '0) state <= BURST;
          end
        end
        BURST: begin
          addr_q  <= addr_q + ADDR_WIDTH'(1);
          count_q <= count_q - LEN_W'(1);
          if (count_q == '0) state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ld_wr) mem[ld_addr] <= ld_data;
  end

  // Registered read, enabled per beat so the data holds between bursts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (issue) begin
      rd_q <= mem[issue_addr];
    end
  end

  rom_rd_pipe #(
    .DEPTH      (RD_LATENCY),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue),
    .in_last   (issue && issue_last),
    .in_data   (rd_q),
    .out_valid (rsp_valid),
    .out_last  (rsp_last),
    .out_data  (rsp_data)
  );

endmodule

// File: tb/tb_burst_rom.sv
// tb/tb_burst_rom.sv - directed bench for burst_rom (latency 1 and latency 3)
module tb_burst_rom;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [14:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic        rsp_valid, rsp_last;
  logic [7:0]  rsp_data;
  logic        ld_en = 1'b0, ld_err;
  logic [14:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;

  logic        b_req_valid = 1'b0, b_req_ready;
  logic [14:0] b_req_addr = '0;
  logic [3:0]  b_req_len = '0;
  logic        b_rsp_valid, b_rsp_last;
  logic [7:0]  b_rsp_data;
  logic        b_ld_en = 1'b0, b_ld_err;
  logic [14:0] b_ld_addr = '0;
  logic [7:0]  b_ld_data = '0;

  burst_rom dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err)
  );

  burst_rom #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr), .req_len(b_req_len),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_last(b_rsp_last),
    .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data), .ld_err(b_ld_err)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int err_pulses = 0;

  logic [7:0] q_data[$];
  logic       q_last[$];
  int         q_cyc[$];
  logic [7:0] q3_data[$];
  logic       q3_last[$];
  int         q3_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_valid) begin
      q_data.push_back(rsp_data); q_last.push_back(rsp_last); q_cyc.push_back(cyc);
    end
    if (b_rsp_valid) begin
      q3_data.push_back(b_rsp_data); q3_last.push_back(b_rsp_last); q3_cyc.push_back(cyc);
    end
    if (ld_err) err_pulses++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic clear_q();
    q_data.delete(); q_last.delete(); q_cyc.delete();
    q3_data.delete(); q3_last.delete(); q3_cyc.delete();
  endtask

  task automatic load(input logic [14:0] a, input logic [7:0] d);
    @(negedge clk); ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk); ld_en = 1'b0;
  endtask

  task automatic load_b(input logic [14:0] a, input logic [7:0] d);
    @(negedge clk); b_ld_en = 1'b1; b_ld_addr = a; b_ld_data = d;
    @(negedge clk); b_ld_en = 1'b0;
  endtask

  // Presents a request for one cycle (caller guarantees req_ready);
  // acc is the accept cycle number.
  task automatic send_req(input logic [14:0] a, input logic [3:0] l, output int acc);
    @(negedge clk); req_valid = 1'b1; req_addr = a; req_len = l; acc = cyc;
    @(negedge clk); req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready got=%b exp=0", req_ready); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_last !== 1'b0) $display("FAIL rst_rsp_last got=%b exp=0", rsp_last); else pass_cnt++;
    total_cnt++; if (ld_err !== 1'b0) $display("FAIL rst_ld_err got=%b exp=0", ld_err); else pass_cnt++;
    total_cnt++; if (rsp_data !== 8'h00) $display("FAIL rst_rsp_data got=%h exp=00", rsp_data); else pass_cnt++;
    total_cnt++; if (b_rsp_data !== 8'h00) $display("FAIL rst_lat3_rsp_data got=%h exp=00", b_rsp_data); else pass_cnt++;
    total_cnt++; if (b_rsp_valid !== 1'b0) $display("FAIL rst_lat3_rsp_valid got=%b exp=0", b_rsp_valid); else pass_cnt++;
    rst_n = 1'b1; #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", req_ready); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_load_read();
    int acc;
    load(15'h0010, 8'hA5);
    load(15'h0011, 8'h3C);
    clear_q();
    @(negedge clk); req_valid = 1'b1; req_addr = 15'h0010; req_len = 4'd1; #1;
    acc = cyc;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL lr_accept_ready got=%b exp=1", req_ready); else pass_cnt++;
    @(negedge clk); req_valid = 1'b0; #1;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL lr_busy_ready got=%b exp=0", req_ready); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL lr_ready_after_issue got=%b exp=1", req_ready); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (q_data.size() !== 2) $display("FAIL lr_beats got=%0d exp=2", q_data.size()); else pass_cnt++;
    if (q_data.size() == 2) begin
      total_cnt++; if (q_data[0] !== 8'hA5) $display("FAIL lr_beat0 got=%h exp=a5", q_data[0]); else pass_cnt++;
      total_cnt++; if (q_data[1] !== 8'h3C) $display("FAIL lr_beat1 got=%h exp=3c", q_data[1]); else pass_cnt++;
      total_cnt++; if (q_last[0] !== 1'b0) $display("FAIL lr_last0 got=%b exp=0", q_last[0]); else pass_cnt++;
      total_cnt++; if (q_last[1] !== 1'b1) $display("FAIL lr_last1 got=%b exp=1", q_last[1]); else pass_cnt++;
      total_cnt++; if (q_cyc[0] !== acc + 1) $display("FAIL lr_cyc0 got=%0d exp=%0d", q_cyc[0], acc + 1); else pass_cnt++;
      total_cnt++; if (q_cyc[1] !== acc + 2) $display("FAIL lr_cyc1 got=%0d exp=%0d", q_cyc[1], acc + 2); else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    int acc;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    load(15'h7FFE, 8'h11); load(15'h7FFF, 8'h22);
    load(15'h0000, 8'h33); load(15'h0001, 8'h44);
    clear_q();
    send_req(15'h7FFE, 4'd3, acc);
    repeat (6) @(negedge clk);
    total_cnt++; if (q_data.size() !== 4) $display("FAIL wrap_beats got=%0d exp=4", q_data.size()); else pass_cnt++;
    if (q_data.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        total_cnt++; if (q_data[i] !== exp_d[i]) $display("FAIL wrap_data%0d got=%h exp=%h", i, q_data[i], exp_d[i]); else pass_cnt++;
        total_cnt++; if (q_last[i] !== (i == 3)) $display("FAIL wrap_last%0d got=%b exp=%b", i, q_last[i], (i == 3)); else pass_cnt++;
        total_cnt++; if (q_cyc[i] !== acc + 1 + i) $display("FAIL wrap_cyc%0d got=%0d exp=%0d", i, q_cyc[i], acc + 1 + i); else pass_cnt++;
      end
    end
  endtask

  task automatic test_load_during_burst();
    int acc;
    for (int i = 0; i < 16; i++) load(15'h0020 + 15'(i), 8'h80 + 8'(i));
    load(15'h0200, 8'h5A);
    clear_q();
    err_pulses = 0;
    send_req(15'h0020, 4'd15, acc);
    ld_en = 1'b1; ld_addr = 15'h0200; ld_data = 8'hFF;
    @(negedge clk); ld_en = 1'b0;
    repeat (20) @(negedge clk);
    total_cnt++; if (err_pulses !== 1) $display("FAIL ldb_err_pulses got=%0d exp=1", err_pulses); else pass_cnt++;
    total_cnt++; if (q_data.size() !== 16) $display("FAIL ldb_beats got=%0d exp=16", q_data.size()); else pass_cnt++;
    if (q_data.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        total_cnt++; if (q_data[i] !== 8'h80 + 8'(i)) $display("FAIL ldb_data%0d got=%h exp=%h", i, q_data[i], 8'h80 + 8'(i)); else pass_cnt++;
        total_cnt++; if (q_last[i] !== (i == 15)) $display("FAIL ldb_last%0d got=%b exp=%b", i, q_last[i], (i == 15)); else pass_cnt++;
      end
    end
    clear_q();
    send_req(15'h0200, 4'd0, acc);
    repeat (3) @(negedge clk);
    total_cnt++; if (q_data.size() !== 1) $display("FAIL ldb_reread_beats got=%0d exp=1", q_data.size()); else pass_cnt++;
    if (q_data.size() == 1) begin
      total_cnt++; if (q_data[0] !== 8'h5A) $display("FAIL ldb_old_value got=%h exp=5a", q_data[0]); else pass_cnt++;
    end
  endtask

  task automatic test_collision();
    int acc;
    clear_q();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 15'h0030; req_len = 4'd0;
    ld_en = 1'b1; ld_addr = 15'h0030; ld_data = 8'h99; #1;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL col_ready_load got=%b exp=0", req_ready); else pass_cnt++;
    @(negedge clk); ld_en = 1'b0; #1;
    acc = cyc;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL col_ready_next got=%b exp=1", req_ready); else pass_cnt++;
    @(negedge clk); req_valid = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (q_data.size() !== 1) $display("FAIL col_beats got=%0d exp=1", q_data.size()); else pass_cnt++;
    if (q_data.size() == 1) begin
      total_cnt++; if (q_data[0] !== 8'h99) $display("FAIL col_data got=%h exp=99", q_data[0]); else pass_cnt++;
      total_cnt++; if (q_last[0] !== 1'b1) $display("FAIL col_last got=%b exp=1", q_last[0]); else pass_cnt++;
      total_cnt++; if (q_cyc[0] !== acc + 1) $display("FAIL col_cyc got=%0d exp=%0d", q_cyc[0], acc + 1); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    load_b(15'h0040, 8'hC1);
    load_b(15'h0041, 8'hC2);
    clear_q();
    @(negedge clk); b_req_valid = 1'b1; b_req_addr = 15'h0040; b_req_len = 4'd0; #1;
    acc = cyc;
    total_cnt++; if (b_req_ready !== 1'b1) $display("FAIL b2b_ready0 got=%b exp=1", b_req_ready); else pass_cnt++;
    @(negedge clk); b_req_addr = 15'h0041; #1;
    total_cnt++; if (b_req_ready !== 1'b1) $display("FAIL b2b_ready1 got=%b exp=1", b_req_ready); else pass_cnt++;
    @(negedge clk); b_req_valid = 1'b0;
    repeat (6) @(negedge clk);
    total_cnt++; if (q3_data.size() !== 2) $display("FAIL b2b_beats got=%0d exp=2", q3_data.size()); else pass_cnt++;
    if (q3_data.size() == 2) begin
      total_cnt++; if (q3_cyc[0] !== acc + 3) $display("FAIL b2b_cyc0 got=%0d exp=%0d", q3_cyc[0], acc + 3); else pass_cnt++;
      total_cnt++; if (q3_cyc[1] !== acc + 4) $display("FAIL b2b_cyc1 got=%0d exp=%0d", q3_cyc[1], acc + 4); else pass_cnt++;
      total_cnt++; if (q3_data[0] !== 8'hC1) $display("FAIL b2b_data0 got=%h exp=c1", q3_data[0]); else pass_cnt++;
      total_cnt++; if (q3_data[1] !== 8'hC2) $display("FAIL b2b_data1 got=%h exp=c2", q3_data[1]); else pass_cnt++;
      total_cnt++; if (q3_last[0] !== 1'b1) $display("FAIL b2b_last0 got=%b exp=1", q3_last[0]); else pass_cnt++;
      total_cnt++; if (q3_last[1] !== 1'b1) $display("FAIL b2b_last1 got=%b exp=1", q3_last[1]); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_burst();
    int acc;
    clear_q();
    send_req(15'h0020, 4'd15, acc);
    while (cyc < acc + 5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL mrst_valid_in_reset got=%b exp=0", rsp_valid); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1; #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL mrst_ready_release got=%b exp=1", req_ready); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL mrst_valid_after got=%b exp=0", rsp_valid); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL mrst_ready_after got=%b exp=1", req_ready); else pass_cnt++;
    repeat (20) @(negedge clk);
    total_cnt++; if (q_data.size() !== 5) $display("FAIL mrst_beats got=%0d exp=5", q_data.size()); else pass_cnt++;
    if (q_data.size() == 5) begin
      total_cnt++; if (q_data[4] !== 8'h84) $display("FAIL mrst_beat4 got=%h exp=84", q_data[4]); else pass_cnt++;
    end
    clear_q();
    send_req(15'h0025, 4'd0, acc);
    send_req(15'h0010, 4'd0, acc);
    repeat (3) @(negedge clk);
    total_cnt++; if (q_data.size() !== 2) $display("FAIL mrst_reread_beats got=%0d exp=2", q_data.size()); else pass_cnt++;
    if (q_data.size() == 2) begin
      total_cnt++; if (q_data[0] !== 8'h85) $display("FAIL mrst_mem_25 got=%h exp=85", q_data[0]); else pass_cnt++;
      total_cnt++; if (q_data[1] !== 8'hA5) $display("FAIL mrst_mem_10 got=%h exp=a5", q_data[1]); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_wrap();
    test_load_during_burst();
    test_collision();
    test_back_to_back();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
